// File: rtl/fft_out_reorder.sv
// fft_out_reorder: captures a parallel FFT output frame into one of two banks,
// then streams it one complex sample per beat in natural bin order over a
// valid/ready interface. The second bank absorbs one frame of consumer stall.

package fft_out_reorder_pkg;
    localparam int unsigned CP_W = 24;

    typedef struct packed {
        logic signed [CP_W-1:0] r;
        logic signed [CP_W-1:0] i;
    } complex_product_t;
endpackage

module fft_out_reorder
    import fft_out_reorder_pkg::*;
#(
    parameter int unsigned N           = 8,
    parameter bit          BIT_REVERSE = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  complex_product_t [N-1:0] fft_in,
    output complex_product_t         out_data,
    output logic [$clog2(N)-1:0]     out_index,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     overflow
);
    localparam int unsigned      IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    // Number of frames held: the read bank is busy in ONE, both banks in FULL.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fill_e;

    // Reverse the IDX_W least significant bits of a bin number.
    function automatic logic [IDX_W-1:0] bitrev(input logic [IDX_W-1:0] m);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int b = 0; b < int'(IDX_W); b++) begin
            r[b] = m[IDX_W-1-b];
        end
        return r;
    endfunction

    fill_e                    fill_q, fill_d;
    logic                     wr_bank_q, wr_bank_d;
    logic                     rd_bank_q, rd_bank_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     in_valid_prev_q, in_valid_prev_d;
    logic                     overflow_q, overflow_d;
    complex_product_t [N-1:0] bank_q [2];
    complex_product_t [N-1:0] bank_d [2];

    logic                     xfer_s;
    logic                     final_s;
    logic                     capture_s;
    logic                     space_s;
    logic                     accept_s;
    logic [IDX_W-1:0]         rd_addr_s;

    // Read side: status and the reorder mux, all derived from registered state.
    always_comb begin
        out_valid = (fill_q != EMPTY);
        out_index = idx_q;
        out_last  = out_valid & (idx_q == LAST_IDX);
        if (BIT_REVERSE) begin
            rd_addr_s = bitrev(idx_q);
        end else begin
            rd_addr_s = idx_q;
        end
        out_data = bank_q[rd_bank_q][rd_addr_s];
        overflow = overflow_q;
    end

    // Handshake, capture edge detection and space check. A final beat frees
    // the read bank in the same cycle, so a FULL buffer can still accept.
    always_comb begin
        xfer_s    = out_valid & out_ready;
        final_s   = xfer_s & (idx_q == LAST_IDX);
        capture_s = in_valid & ~in_valid_prev_q;
        space_s   = (fill_q != FULL) | final_s;
        accept_s  = capture_s & space_s;
    end

    // Next-state for fill level, bank pointers, read index and sticky overflow.
    always_comb begin
        fill_d          = fill_q;
        wr_bank_d       = wr_bank_q;
        rd_bank_d       = rd_bank_q;
        idx_d           = idx_q;
        in_valid_prev_d = in_valid;
        overflow_d      = overflow_q;

        case (fill_q)
            EMPTY: begin
                if (accept_s) begin
                    fill_d = ONE;
                end else begin
                    fill_d = EMPTY;
                end
            end
            ONE: begin
                if (accept_s && !final_s) begin
                    fill_d = FULL;
                end else if (final_s && !accept_s) begin
                    fill_d = EMPTY;
                end else begin
                    fill_d = ONE;
                end
            end
            FULL: begin
                if (final_s && !accept_s) begin
                    fill_d = ONE;
                end else begin
                    fill_d = FULL;
                end
            end
            default: begin
                fill_d = EMPTY;
            end
        endcase

        if (accept_s) begin
            wr_bank_d = ~wr_bank_q;
        end else begin
            wr_bank_d = wr_bank_q;
        end

        if (final_s) begin
            idx_d     = '0;
            rd_bank_d = ~rd_bank_q;
        end else if (xfer_s) begin
            idx_d     = idx_q + IDX_W'(1);
            rd_bank_d = rd_bank_q;
        end else begin
            idx_d     = idx_q;
            rd_bank_d = rd_bank_q;
        end

        if (capture_s && !space_s) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Frame write: the whole parallel frame lands in the write bank at once.
    always_comb begin
        bank_d = bank_q;
        if (accept_s) begin
            bank_d[wr_bank_q] = fft_in;
        end else begin
            bank_d = bank_q;
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q          <= EMPTY;
            wr_bank_q       <= 1'b0;
            rd_bank_q       <= 1'b0;
            idx_q           <= '0;
            in_valid_prev_q <= 1'b0;
            overflow_q      <= 1'b0;
        end else begin
            fill_q          <= fill_d;
            wr_bank_q       <= wr_bank_d;
            rd_bank_q       <= rd_bank_d;
            idx_q           <= idx_d;
            in_valid_prev_q <= in_valid_prev_d;
            overflow_q      <= overflow_d;
        end
    end

    // Sample storage; contents are meaningless while EMPTY, so no reset.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Bench for fft_out_reorder: two instances (bit-reversed and pass-through
// order) share stimulus and are compared every cycle against a frame-queue
// reference model, plus directed checks of the documented scenarios.

module tb_fft_out_reorder;
    import fft_out_reorder_pkg::*;

    localparam int N  = 8;
    localparam int LW = $clog2(N);
    localparam int VW = 3 + LW + 2 * CP_W;

    typedef complex_product_t [N-1:0] frame_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     in_valid;
    logic                     out_ready;
    complex_product_t [N-1:0] fft_in;
    complex_product_t         data_b, data_n;
    logic [LW-1:0]            index_b, index_n;
    logic                     valid_b, valid_n, last_b, last_n, ovf_b, ovf_n;

    int checks   = 0;
    int failures = 0;
    bit use_pattern = 1'b0;

    always #5 clk = ~clk;

    fft_out_reorder #(.N(N), .BIT_REVERSE(1'b1)) dut_br (
        .clk(clk), .reset(reset), .in_valid(in_valid), .fft_in(fft_in),
        .out_data(data_b), .out_index(index_b), .out_valid(valid_b),
        .out_ready(out_ready), .out_last(last_b), .overflow(ovf_b)
    );

    fft_out_reorder #(.N(N), .BIT_REVERSE(1'b0)) dut_nat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .fft_in(fft_in),
        .out_data(data_n), .out_index(index_n), .out_valid(valid_n),
        .out_ready(out_ready), .out_last(last_n), .overflow(ovf_n)
    );

    // Reference model: a queue of stored frames (at most two), a beat pointer
    // into the head frame, and a sticky drop flag.
    frame_t m_frames[$];
    int     m_pos = 0;
    bit     m_prev = 1'b0;
    bit     m_ov = 1'b0;
    bit     m_xfer, m_fin, m_cap;

    always @(posedge clk) begin
        if (reset === 1'b1) begin
            m_frames.delete();
            m_pos  = 0;
            m_prev = 1'b0;
            m_ov   = 1'b0;
        end else begin
            m_xfer = (m_frames.size() != 0) && (out_ready === 1'b1);
            m_fin  = m_xfer && (m_pos == N - 1);
            m_cap  = (in_valid === 1'b1) && !m_prev;
            m_prev = (in_valid === 1'b1);
            if (m_xfer) m_pos = m_fin ? 0 : m_pos + 1;
            if (m_fin) void'(m_frames.pop_front());
            if (m_cap) begin
                if (m_frames.size() < 2) m_frames.push_back(fft_in);
                else m_ov = 1'b1;
            end
        end
    end

    function automatic int bitrev(input int m);
        int r = 0;
        for (int b = 0; b < LW; b++) r = r * 2 + ((m >> b) & 1);
        return r;
    endfunction

    function automatic logic [VW-1:0] exp_vec(input bit br);
        frame_t f;
        int     src;
        if (m_frames.size() == 0)
            return {1'b0, 1'b0, LW'(m_pos), m_ov, {(2 * CP_W){1'b0}}};
        f   = m_frames[0];
        src = br ? bitrev(m_pos) : m_pos;
        return {1'b1, (m_pos == N - 1), LW'(m_pos), m_ov, f[src]};
    endfunction

    function automatic logic [VW-1:0] obs_vec(input bit br);
        logic [2*CP_W-1:0] d;
        if (br) begin
            d = valid_b ? data_b : '0;
            return {valid_b, last_b, index_b, ovf_b, d};
        end
        d = valid_n ? data_n : '0;
        return {valid_n, last_n, index_n, ovf_n, d};
    endfunction

    // One clock: drive inputs at the falling edge, return at the next falling edge.
    task automatic tick(input logic iv, input logic rdy, input logic rst);
        reset     = rst;
        in_valid  = iv;
        out_ready = rdy;
        if (!use_pattern) begin
            for (int k = 0; k < N; k++) begin
                fft_in[k].r = CP_W'($urandom);
                fft_in[k].i = CP_W'($urandom);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b1);
        checks += 2;
        if ({valid_b, last_b, index_b, ovf_b} !== {1'b0, 1'b0, LW'(0), 1'b0}) begin
            failures++;
            $display("FAIL reset_br got v/l/idx/ovf=%b/%b/%0d/%b want 0/0/0/0", valid_b, last_b, index_b, ovf_b);
        end
        if ({valid_n, last_n, index_n, ovf_n} !== {1'b0, 1'b0, LW'(0), 1'b0}) begin
            failures++;
            $display("FAIL reset_nat got v/l/idx/ovf=%b/%b/%0d/%b want 0/0/0/0", valid_n, last_n, index_n, ovf_n);
        end
    endtask

    task automatic test_single_frame();
        tick(1'b0, 1'b0, 1'b1);
        use_pattern = 1'b1;
        for (int k = 0; k < N; k++) begin
            fft_in[k].r = CP_W'(100 * k);
            fft_in[k].i = CP_W'(-k);
        end
        for (int k = 0; k < N; k++) begin
            tick(k == 0, 1'b1, 1'b0);
            checks += 4;
            if (!valid_b || data_b.r !== CP_W'(100 * bitrev(k)) || data_b.i !== CP_W'(-bitrev(k))
                || index_b !== LW'(k) || last_b !== (k == N - 1)) begin
                failures++;
                $display("FAIL single_br beat %0d got v=%b r=%0d i=%0d idx=%0d last=%b want r=%0d i=%0d",
                         k, valid_b, data_b.r, data_b.i, index_b, last_b, 100 * bitrev(k), -bitrev(k));
            end
            if (!valid_n || data_n.r !== CP_W'(100 * k) || data_n.i !== CP_W'(-k)
                || index_n !== LW'(k) || last_n !== (k == N - 1)) begin
                failures++;
                $display("FAIL single_nat beat %0d got v=%b r=%0d i=%0d idx=%0d last=%b want r=%0d i=%0d",
                         k, valid_n, data_n.r, data_n.i, index_n, last_n, 100 * k, -k);
            end
            if (obs_vec(1'b1) !== exp_vec(1'b1)) begin
                failures++;
                $display("FAIL single_model_br got %h want %h", obs_vec(1'b1), exp_vec(1'b1));
            end
            if (obs_vec(1'b0) !== exp_vec(1'b0)) begin
                failures++;
                $display("FAIL single_model_nat got %h want %h", obs_vec(1'b0), exp_vec(1'b0));
            end
        end
        tick(1'b0, 1'b1, 1'b0);
        use_pattern = 1'b0;
        checks++;
        if (valid_b !== 1'b0 || valid_n !== 1'b0) begin
            failures++;
            $display("FAIL single_drained got valid br/nat=%b/%b want 0/0", valid_b, valid_n);
        end
    endtask

    task automatic test_stall();
        int  ntx = 0;
        logic rdy;
        tick(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 18; c++) begin
            rdy = !(c >= 4 && c < 9);
            if (valid_b && rdy) ntx++;
            tick(c == 0, rdy, 1'b0);
            checks += 2;
            if (obs_vec(1'b1) !== exp_vec(1'b1) || obs_vec(1'b0) !== exp_vec(1'b0)) begin
                failures++;
                $display("FAIL stall_model cycle %0d got %h/%h want %h/%h", c,
                         obs_vec(1'b1), obs_vec(1'b0), exp_vec(1'b1), exp_vec(1'b0));
            end
            if (c >= 4 && c < 9 && (valid_b !== 1'b1 || index_b !== LW'(3))) begin
                failures++;
                $display("FAIL stall_hold cycle %0d got v=%b idx=%0d want v=1 idx=3", c, valid_b, index_b);
            end
        end
        checks++;
        if (ntx != N) begin
            failures++;
            $display("FAIL stall_beats got %0d want %0d", ntx, N);
        end
    endtask

    task automatic test_overflow();
        int   ntx = 0, first = -1, lastc = -1;
        logic rdy;
        tick(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 26; c++) begin
            rdy = (c >= 6);
            if (valid_b && rdy) begin
                ntx++;
                if (first < 0) first = c;
                lastc = c;
            end
            tick(c == 0 || c == 2 || c == 4, rdy, 1'b0);
            checks += 2;
            if (obs_vec(1'b1) !== exp_vec(1'b1) || obs_vec(1'b0) !== exp_vec(1'b0)) begin
                failures++;
                $display("FAIL ovf_model cycle %0d got %h/%h want %h/%h", c,
                         obs_vec(1'b1), obs_vec(1'b0), exp_vec(1'b1), exp_vec(1'b0));
            end
            if (c >= 5 && ovf_b !== 1'b1) begin
                failures++;
                $display("FAIL ovf_sticky cycle %0d got %b want 1", c, ovf_b);
            end
        end
        checks++;
        if (ntx != 2 * N || lastc - first != 2 * N - 1 || valid_b !== 1'b0) begin
            failures++;
            $display("FAIL ovf_two_frames got beats=%0d span=%0d v=%b want beats=%0d span=%0d v=0",
                     ntx, lastc - first + 1, valid_b, 2 * N, 2 * N);
        end
    endtask

    task automatic test_full_capture();
        int   ntx = 0, first = -1, lastc = -1;
        logic rdy;
        tick(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 34; c++) begin
            rdy = (c >= 6);
            if (valid_b && rdy) begin
                ntx++;
                if (first < 0) first = c;
                lastc = c;
            end
            tick(c == 0 || c == 2 || c == 6 + N - 1, rdy, 1'b0);
            checks += 2;
            if (obs_vec(1'b1) !== exp_vec(1'b1) || obs_vec(1'b0) !== exp_vec(1'b0)) begin
                failures++;
                $display("FAIL full_model cycle %0d got %h/%h want %h/%h", c,
                         obs_vec(1'b1), obs_vec(1'b0), exp_vec(1'b1), exp_vec(1'b0));
            end
            if (ovf_b !== 1'b0) begin
                failures++;
                $display("FAIL full_no_ovf cycle %0d got %b want 0", c, ovf_b);
            end
        end
        checks++;
        if (ntx != 3 * N || lastc - first != 3 * N - 1 || valid_b !== 1'b0) begin
            failures++;
            $display("FAIL full_three_frames got beats=%0d span=%0d v=%b want beats=%0d span=%0d v=0",
                     ntx, lastc - first + 1, valid_b, 3 * N, 3 * N);
        end
    endtask

    task automatic test_level_and_reset();
        int ntx = 0;
        tick(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 25; c++) begin
            if (valid_b) ntx++;
            tick(c < 20, 1'b1, 1'b0);
            checks++;
            if (obs_vec(1'b1) !== exp_vec(1'b1)) begin
                failures++;
                $display("FAIL level_model cycle %0d got %h want %h", c, obs_vec(1'b1), exp_vec(1'b1));
            end
        end
        checks++;
        if (ntx != N || valid_b !== 1'b0) begin
            failures++;
            $display("FAIL level_one_frame got beats=%0d v=%b want beats=%0d v=0", ntx, valid_b, N);
        end
        for (int d = 0; d < 14; d++) begin
            tick(d == 0 || d == 6, 1'b1, d == 5);
            checks += 2;
            if (obs_vec(1'b1) !== exp_vec(1'b1) || obs_vec(1'b0) !== exp_vec(1'b0)) begin
                failures++;
                $display("FAIL midreset_model step %0d got %h/%h want %h/%h", d,
                         obs_vec(1'b1), obs_vec(1'b0), exp_vec(1'b1), exp_vec(1'b0));
            end
            if (d == 5 && (valid_b !== 1'b0 || index_b !== LW'(0) || valid_n !== 1'b0)) begin
                failures++;
                $display("FAIL midreset_abandon got v=%b idx=%0d want v=0 idx=0", valid_b, index_b);
            end
            if (d == 6 && (valid_b !== 1'b1 || index_b !== LW'(0))) begin
                failures++;
                $display("FAIL midreset_restart got v=%b idx=%0d want v=1 idx=0", valid_b, index_b);
            end
        end
    endtask

    task automatic test_random();
        tick(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 400; c++) begin
            tick($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 1'b0);
            checks += 2;
            if (obs_vec(1'b1) !== exp_vec(1'b1)) begin
                failures++;
                $display("FAIL random_br cycle %0d got %h want %h", c, obs_vec(1'b1), exp_vec(1'b1));
            end
            if (obs_vec(1'b0) !== exp_vec(1'b0)) begin
                failures++;
                $display("FAIL random_nat cycle %0d got %h want %h", c, obs_vec(1'b0), exp_vec(1'b0));
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        fft_in    = '0;
        @(negedge clk);
        test_reset();
        test_single_frame();
        test_stall();
        test_overflow();
        test_full_capture();
        test_level_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
